// File: rtl/cia_pkg.sv
// Shared types and helpers for the CIA bus synchronizer.
package cia;

  // Bus-cycle tracking states.
  typedef enum logic [1:0] {
    LOW  = 2'd0,
    WAIT = 2'd1,
    ACC  = 2'd2
  } state_t;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 8;

  // Bits needed to hold a count from 0 up to n inclusive.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/cia_sync_filter.sv
// Two-flop synchronizer followed by a run-length glitch filter.
// level changes only after FILTER_LEN consecutive synchronized samples
// disagree with it; level_c is the value level takes on the next edge.
module cia_sync_filter
  import cia::*;
#(
  parameter int unsigned FILTER_LEN = 3,
  parameter logic        RST_VAL    = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic level,
  output logic level_c
);

  localparam int unsigned CNT_W = cnt_width(FILTER_LEN);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  // Metastability guard for the asynchronous pad level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= RST_VAL;
      s2 <= RST_VAL;
    end else begin
      s1 <= d;
      s2 <= s1;
    end
  end

  assign accept  = (s2 != level) && (cnt == CNT_W'(FILTER_LEN - 1));
  assign level_c = accept ? s2 : level;

  // Count the run of samples that disagree with the accepted level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      level <= RST_VAL;
    end else begin
      level <= level_c;
      if ((s2 == level) || accept) cnt <= '0;
      else                         cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/cia_bus_sync.sv
// Synchronizes the 6526 CPU-side bus into the clk domain and turns each
// PHI2 cycle into at most one single-cycle read or write strobe.
module cia_bus_sync
  import cia::*;
#(
  parameter int unsigned FILTER_LEN = 3,
  parameter int unsigned ADDR_DLY   = 4,
  parameter int unsigned TIMEOUT    = 48
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        phi2_i,
  input  logic        res_n_i,
  input  logic        cs_n_i,
  input  logic        r_w_n_i,
  input  logic [3:0]  addr_i,
  input  logic [7:0]  data_i,
  output logic        phi2_o,
  output logic        phi2_rise_o,
  output logic        phi2_fall_o,
  output logic        res_o,
  output logic        rd_stb_o,
  output logic        wr_stb_o,
  output logic [3:0]  addr_o,
  output logic [7:0]  wdata_o,
  output logic        phi2_lost_o
);

  localparam int unsigned DLY_W = cnt_width(ADDR_DLY);
  localparam int unsigned WD_W  = cnt_width(TIMEOUT);

  logic              phi_level;
  logic              phi_level_c;
  logic              resn_level;
  logic              resn_level_c;
  logic              phi_rise_c;
  logic              phi_fall_c;
  logic              res_c;

  logic              cs_n_s1;
  logic              cs_n_s2;
  logic              r_w_n_s1;
  logic              r_w_n_s2;
  logic [ADDR_W-1:0] addr_s1;
  logic [ADDR_W-1:0] addr_s2;
  logic [DATA_W-1:0] data_s1;
  logic [DATA_W-1:0] data_s2;

  logic [WD_W-1:0]   wd;
  logic [WD_W-1:0]   wd_next;
  logic              lost_c;
  logic              blocked_c;

  state_t            state;
  logic [DLY_W-1:0]  dly;
  logic              armed;
  logic              acc_cs_n;
  logic              acc_r_w_n;

  cia_sync_filter #(
    .FILTER_LEN (FILTER_LEN),
    .RST_VAL    (1'b0)
  ) u_phi2_filter (
    .clk     (clk),
    .rst_n   (rst_n),
    .d       (phi2_i),
    .level   (phi_level),
    .level_c (phi_level_c)
  );

  cia_sync_filter #(
    .FILTER_LEN (FILTER_LEN),
    .RST_VAL    (1'b0)
  ) u_res_filter (
    .clk     (clk),
    .rst_n   (rst_n),
    .d       (res_n_i),
    .level   (resn_level),
    .level_c (resn_level_c)
  );

  assign phi2_o     = phi_level;
  assign res_o      = ~resn_level;
  assign phi_rise_c = phi_level_c & ~phi_level;
  assign phi_fall_c = ~phi_level_c & phi_level;
  assign res_c      = ~resn_level_c;

  // Plain two-flop stages for the bus signals; they are only sampled
  // long after PHI2 edges, so no filtering is needed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_n_s1  <= 1'b1;
      cs_n_s2  <= 1'b1;
      r_w_n_s1 <= 1'b1;
      r_w_n_s2 <= 1'b1;
      addr_s1  <= '0;
      addr_s2  <= '0;
      data_s1  <= '0;
      data_s2  <= '0;
    end else begin
      cs_n_s1  <= cs_n_i;
      cs_n_s2  <= cs_n_s1;
      r_w_n_s1 <= r_w_n_i;
      r_w_n_s2 <= r_w_n_s1;
      addr_s1  <= addr_i;
      addr_s2  <= addr_s1;
      data_s1  <= data_i;
      data_s2  <= data_s1;
    end
  end

  // Single-cycle PHI2 edge strobes aligned with the filtered level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phi2_rise_o <= 1'b0;
      phi2_fall_o <= 1'b0;
    end else begin
      phi2_rise_o <= phi_rise_c;
      phi2_fall_o <= phi_fall_c;
    end
  end

  // Watchdog next count: cleared by an accepted rise, saturating at TIMEOUT.
  always_comb begin
    wd_next = wd;
    if (phi_rise_c)                 wd_next = '0;
    else if (wd != WD_W'(TIMEOUT))  wd_next = wd + WD_W'(1);
  end

  assign lost_c    = (wd_next == WD_W'(TIMEOUT));
  assign blocked_c = phi2_lost_o | lost_c;

  // Watchdog register; the lost flag tracks the saturated count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd          <= '0;
      phi2_lost_o <= 1'b0;
    end else begin
      wd          <= wd_next;
      phi2_lost_o <= lost_c;
    end
  end

  // Bus-cycle FSM: capture ADDR_DLY cycles after an accepted rise, strobe
  // reads on capture and writes on the following fall. The first rise after
  // reset is ignored until a full fall has been seen (armed).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= LOW;
      dly       <= '0;
      armed     <= 1'b0;
      acc_cs_n  <= 1'b1;
      acc_r_w_n <= 1'b1;
      addr_o    <= '0;
      wdata_o   <= '0;
      rd_stb_o  <= 1'b0;
      wr_stb_o  <= 1'b0;
    end else begin
      rd_stb_o <= 1'b0;
      wr_stb_o <= 1'b0;
      if (phi_fall_c) armed <= 1'b1;
      if (blocked_c) begin
        state <= LOW;
      end else begin
        case (state)
          LOW: begin
            if (phi_rise_c && armed) begin
              state <= WAIT;
              dly   <= '0;
            end
          end
          WAIT: begin
            if (phi_fall_c) begin
              state <= LOW;
            end else if (dly == DLY_W'(ADDR_DLY - 1)) begin
              state     <= ACC;
              addr_o    <= addr_s2;
              acc_cs_n  <= cs_n_s2;
              acc_r_w_n <= r_w_n_s2;
              rd_stb_o  <= ~cs_n_s2 & r_w_n_s2 & ~res_c;
            end else begin
              dly <= dly + DLY_W'(1);
            end
          end
          ACC: begin
            if (phi_fall_c) begin
              state <= LOW;
              if (!acc_cs_n && !acc_r_w_n) begin
                wdata_o  <= data_s2;
                wr_stb_o <= ~res_c;
              end
            end
          end
          default: state <= LOW;
        endcase
      end
    end
  end

endmodule
